// File: rtl/hdmi_sup_pkg.sv
// hdmi_sup_pkg
//   Shared definitions for the HDMI link supervisor: the state encoding
//   exposed on the `state` port and helpers that size the internal
//   counters from the top-level parameters.
package hdmi_sup_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RESET   = 3'd1,
    ST_ACQUIRE = 3'd2,
    ST_LOCKED  = 3'd3
  } sup_state_e;

  // Ceiling for the saturating 8-bit event counters.
  localparam logic [7:0] SAT8 = 8'hFF;

  // Width of the shared dwell/leaky counter: it must reach the longest
  // backed-off acquire timeout, the loss threshold and the lock run.
  function automatic int cnt_width(input int acq, input int max_bo,
                                   input int loss, input int lock);
    longint m;
    m = longint'(acq) << max_bo;
    if (longint'(loss) > m) m = longint'(loss);
    if (longint'(lock) > m) m = longint'(lock);
    return $clog2(m) + 1;
  endfunction

  // Width of the consecutive-good run counter.
  function automatic int run_width(input int lock);
    return $clog2(lock) + 1;
  endfunction

  // Width of the backoff exponent (0..max_bo), never narrower than 1 bit.
  function automatic int backoff_width(input int max_bo);
    return (max_bo < 1) ? 1 : $clog2(max_bo + 1);
  endfunction

endpackage

// File: rtl/sync2.sv
// sync2
//   Two-flop synchronizer bringing an asynchronous level into clk.
//   Ports: clk, reset (sync, active-high, clears both flops),
//          d (async input), q (synchronized output, 2-cycle latency).
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/hdmi_link_supervisor.sv
// hdmi_link_supervisor
//   Supervises TMDS decoder recovery: holds the decoder in reset, releases
//   it to acquire, qualifies lock over a run of good cycles, watches a
//   leaky loss counter while locked, and retries with exponential backoff.
//   Ports:
//     clk, reset          system clock, synchronous active-high reset
//     enable              low forces IDLE (decoder held in reset)
//     hdmi_valid_in,
//     hdmi_locked_in,
//     vsync_in            asynchronous status from the decoder / stream
//     hdmi_reset          registered reset to the decoder
//     link_up             high only while LOCKED
//     state               current state encoding
//     retry_count         saturating count of acquire timeouts
//     loss_count          saturating count of LOCKED->RESET drops
//     frame_count         wrapping count of vsync falling edges while LOCKED
module hdmi_link_supervisor
  import hdmi_sup_pkg::*;
#(
  parameter int LOCK_CYCLES  = 4096,
  parameter int LOSS_CYCLES  = 1048576,
  parameter int ACQ_TIMEOUT  = 262144,
  parameter int MAX_BACKOFF  = 4,
  parameter int RESET_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        hdmi_valid_in,
  input  logic        hdmi_locked_in,
  input  logic        vsync_in,
  output logic        hdmi_reset,
  output logic        link_up,
  output logic [2:0]  state,
  output logic [7:0]  retry_count,
  output logic [7:0]  loss_count,
  output logic [15:0] frame_count
);

  localparam int CNT_W = cnt_width(ACQ_TIMEOUT, MAX_BACKOFF, LOSS_CYCLES, LOCK_CYCLES);
  localparam int RUN_W = run_width(LOCK_CYCLES);
  localparam int BO_W  = backoff_width(MAX_BACKOFF);

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOSS_LAST = CNT_W'(LOSS_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACQ_BASE  = CNT_W'(ACQ_TIMEOUT);
  localparam logic [RUN_W-1:0] RUN_LAST  = RUN_W'(LOCK_CYCLES - 1);
  localparam logic [BO_W-1:0]  BO_MAX    = BO_W'(MAX_BACKOFF);

  logic valid_s, locked_s, vsync_s, good, vsync_fall;

  sync2 u_sync_valid  (.clk(clk), .reset(reset), .d(hdmi_valid_in),  .q(valid_s));
  sync2 u_sync_locked (.clk(clk), .reset(reset), .d(hdmi_locked_in), .q(locked_s));
  sync2 u_sync_vsync  (.clk(clk), .reset(reset), .d(vsync_in),       .q(vsync_s));

  sup_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, acq_limit;
  logic [RUN_W-1:0] run_q, run_d;
  logic [BO_W-1:0]  backoff_q, backoff_d;
  logic [7:0]       retry_q, retry_d, loss_q, loss_d;
  logic [15:0]      frame_q, frame_d;
  logic             hdmi_reset_q, hdmi_reset_d, link_up_q, link_up_d;
  logic             vsync_prev_q;

  assign good       = valid_s & locked_s;
  assign vsync_fall = vsync_prev_q & ~vsync_s;
  // Last cycle of the current acquire window, doubled on every timeout.
  assign acq_limit  = (ACQ_BASE << backoff_q) - CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    run_d     = '0;
    backoff_d = backoff_q;
    retry_d   = retry_q;
    loss_d    = loss_q;
    frame_d   = frame_q;

    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_RESET;
          cnt_d   = '0;
        end
        ST_RESET: begin
          if (cnt_q == RST_LAST) begin
            state_d = ST_ACQUIRE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_ACQUIRE: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (good) run_d = run_q + RUN_W'(1);
          // Lock qualification is tested first so it wins over a timeout
          // landing on the same cycle.
          if (good && (run_q == RUN_LAST)) begin
            state_d   = ST_LOCKED;
            cnt_d     = '0;
            run_d     = '0;
            backoff_d = '0;
          end else if (cnt_q == acq_limit) begin
            state_d = ST_RESET;
            cnt_d   = '0;
            retry_d = (retry_q == SAT8) ? retry_q : retry_q + 8'd1;
            if (backoff_q != BO_MAX) backoff_d = backoff_q + BO_W'(1);
          end
        end
        ST_LOCKED: begin
          if (vsync_fall) frame_d = frame_q + 16'd1;
          // Leaky integrator: bad cycles fill, good cycles drain to zero.
          if (!good) begin
            if (cnt_q == LOSS_LAST) begin
              state_d = ST_RESET;
              cnt_d   = '0;
              loss_d  = (loss_q == SAT8) ? loss_q : loss_q + 8'd1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Outputs follow the next state so they change together with `state`.
    hdmi_reset_d = (state_d == ST_IDLE) || (state_d == ST_RESET);
    link_up_d    = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      run_q        <= '0;
      backoff_q    <= '0;
      retry_q      <= '0;
      loss_q       <= '0;
      frame_q      <= '0;
      hdmi_reset_q <= 1'b1;
      link_up_q    <= 1'b0;
      vsync_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      run_q        <= run_d;
      backoff_q    <= backoff_d;
      retry_q      <= retry_d;
      loss_q       <= loss_d;
      frame_q      <= frame_d;
      hdmi_reset_q <= hdmi_reset_d;
      link_up_q    <= link_up_d;
      vsync_prev_q <= vsync_s;
    end
  end

  assign hdmi_reset  = hdmi_reset_q;
  assign link_up     = link_up_q;
  assign state       = state_q;
  assign retry_count = retry_q;
  assign loss_count  = loss_q;
  assign frame_count = frame_q;

endmodule

// File: tb/tb_hdmi_link_supervisor.sv
// tb_hdmi_link_supervisor
//   Directed scenarios for lock, backoff, leaky loss, overrides, frames and
//   saturation, plus a randomized run, all tracked cycle by cycle against a
//   behavioural model of the supervisor's rules.
module tb_hdmi_link_supervisor;

  localparam int LOCK_C = 8;
  localparam int LOSS_C = 32;
  localparam int ACQ_C  = 16;
  localparam int MAXB   = 2;
  localparam int RST_C  = 4;

  logic        clk = 1'b0;
  logic        reset, enable, hdmi_valid_in, hdmi_locked_in, vsync_in;
  logic        hdmi_reset, link_up;
  logic [2:0]  state;
  logic [7:0]  retry_count, loss_count;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  hdmi_link_supervisor #(
    .LOCK_CYCLES(LOCK_C), .LOSS_CYCLES(LOSS_C), .ACQ_TIMEOUT(ACQ_C),
    .MAX_BACKOFF(MAXB), .RESET_CYCLES(RST_C)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .hdmi_valid_in(hdmi_valid_in), .hdmi_locked_in(hdmi_locked_in),
    .vsync_in(vsync_in), .hdmi_reset(hdmi_reset), .link_up(link_up),
    .state(state), .retry_count(retry_count), .loss_count(loss_count),
    .frame_count(frame_count)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b1;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Model states by meaning: 0 idle, 1 reset, 2 acquire, 3 locked.
  int m_state, m_dwell, m_run, m_leak, m_backoff, m_retry, m_loss, m_frame;
  bit [2:0] hv, hl, hs;   // input history, bit 0 = most recent edge

  task automatic m_enter(input int s);
    m_state = s;
    m_dwell = 0;
    m_run   = 0;
  endtask

  task automatic model_step();
    bit good, fall;
    good = hv[1] & hl[1];          // value two edges old = synchronizer output
    fall = hs[2] & ~hs[1];
    if (reset) begin
      hv = '0; hl = '0; hs = '0;
      m_enter(0);
      m_leak = 0; m_backoff = 0; m_retry = 0; m_loss = 0; m_frame = 0;
      return;
    end
    hv = {hv[1:0], hdmi_valid_in};
    hl = {hl[1:0], hdmi_locked_in};
    hs = {hs[1:0], vsync_in};
    if (!enable) begin
      m_state = 0;
      return;
    end
    case (m_state)
      0: m_enter(1);
      1: begin
        m_dwell++;
        if (m_dwell == RST_C) m_enter(2);
      end
      2: begin
        m_dwell++;
        m_run = good ? m_run + 1 : 0;
        if (m_run == LOCK_C) begin
          m_backoff = 0;
          m_leak    = 0;
          m_enter(3);
        end else if (m_dwell == (ACQ_C << m_backoff)) begin
          m_retry   = (m_retry < 255) ? m_retry + 1 : 255;
          m_backoff = (m_backoff < MAXB) ? m_backoff + 1 : MAXB;
          m_enter(1);
        end
      end
      default: begin
        if (fall) m_frame = (m_frame + 1) % 65536;
        if (!good) begin
          if (m_leak == LOSS_C - 1) begin
            m_loss = (m_loss < 255) ? m_loss + 1 : 255;
            m_enter(1);
          end else begin
            m_leak++;
          end
        end else if (m_leak > 0) begin
          m_leak--;
        end
      end
    endcase
  endtask

  task automatic cmp_model();
    check_val("state",       state,        m_state);
    check_val("hdmi_reset",  hdmi_reset,   (m_state <= 1) ? 1 : 0);
    check_val("link_up",     link_up,      (m_state == 3) ? 1 : 0);
    check_val("retry_count", retry_count,  m_retry);
    check_val("loss_count",  loss_count,   m_loss);
    check_val("frame_count", frame_count,  m_frame);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (cmp_en) cmp_model();
  endtask

  task automatic set_good(input bit g);
    hdmi_valid_in  = g;
    hdmi_locked_in = g;
  endtask

  task automatic wait_state(input int s, input int limit, input string tag);
    int n = 0;
    while (state != 3'(s) && n < limit) begin
      tick();
      n++;
    end
    check_val(tag, state, s);
  endtask

  task automatic wait_link(input int limit, input string tag);
    int n = 0;
    while (!link_up && n < limit) begin
      tick();
      n++;
    end
    check_val(tag, link_up, 1);
  endtask

  initial begin
    int n, exit_at, seg, mode, prev, tcount;

    reset = 1'b1; enable = 1'b0; set_good(1'b0); vsync_in = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check_val("rst_state", state, 0);
    check_val("rst_hdmi_reset", hdmi_reset, 1);
    check_val("rst_retry", retry_count, 0);

    // ---- basic lock ----
    enable = 1'b1;
    wait_state(1, 20, "lock_enter_reset");
    n = 0;
    while (state == 3'd1 && n < 50) begin
      if (hdmi_reset) n++;
      tick();
    end
    check_val("reset_pulse_len", n, RST_C);
    check_val("acq_hdmi_reset", hdmi_reset, 0);
    set_good(1'b1);
    n = 0;
    while (!link_up && n < 100) begin
      tick();
      n++;
    end
    check_val("lock_latency", n, LOCK_C + 2);
    check_val("lock_retry", retry_count, 0);
    $display("basic lock: latency %0d cycles", n);

    // ---- backoff ----
    reset = 1'b1; set_good(1'b0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_state(2, 300, "backoff_enter_acq");
      n = 1;
      while (state == 3'd2 && n < 300) begin
        tick();
        n++;
      end
      check_val("backoff_dwell", n - 1, ACQ_C << ((k < MAXB) ? k : MAXB));
      check_val("backoff_retry", retry_count, k + 1);
      $display("backoff: acquire %0d dwell %0d retry %0d", k, n - 1, retry_count);
    end

    // ---- leaky loss, 3 bad / 1 good ----
    set_good(1'b1);
    wait_link(300, "leak_lock");
    exit_at = 0;
    for (int i = 1; i <= 200 && exit_at == 0; i++) begin
      set_good((i % 4) == 0);
      tick();
      if (state != 3'd3) exit_at = i;
    end
    check_val("leak_exit_cycle", exit_at, 2 + 2 * 31);
    check_val("leak_exit_state", state, 1);
    check_val("leak_loss", loss_count, 1);
    set_good(1'b0);
    wait_state(2, 50, "leak_reacq");
    n = 1;
    while (state == 3'd2 && n < 300) begin
      tick();
      n++;
    end
    check_val("leak_backoff_cleared", n - 1, ACQ_C);
    $display("leaky loss: exit after %0d cycles, loss %0d", exit_at, loss_count);

    // ---- 1 bad / 1 good stays locked ----
    set_good(1'b1);
    wait_link(300, "alt_lock");
    for (int i = 0; i < 200; i++) begin
      set_good(i[0]);
      tick();
    end
    check_val("alt_link_up", link_up, 1);
    check_val("alt_loss", loss_count, 1);

    // ---- enable and reset override ----
    set_good(1'b0);
    wait_state(2, 300, "ovr_acq");
    enable = 1'b0;
    tick();
    check_val("ovr_en_state", state, 0);
    check_val("ovr_en_hdmi_reset", hdmi_reset, 1);
    enable = 1'b1; set_good(1'b1);
    wait_link(300, "ovr_lock");
    reset = 1'b1;
    tick();
    check_val("ovr_rst_state", state, 0);
    check_val("ovr_rst_hdmi_reset", hdmi_reset, 1);
    check_val("ovr_rst_link_up", link_up, 0);
    check_val("ovr_rst_loss", loss_count, 0);
    check_val("ovr_rst_retry", retry_count, 0);
    reset = 1'b0;

    // ---- frames ----
    wait_link(300, "frm_lock");
    for (int p = 0; p < 5; p++) begin
      vsync_in = 1'b1; repeat (4) tick();
      vsync_in = 1'b0; repeat (4) tick();
    end
    check_val("frm_count", frame_count, 5);
    set_good(1'b0);
    wait_state(1, 300, "frm_unlock");
    for (int p = 0; p < 3; p++) begin
      vsync_in = 1'b1; repeat (3) tick();
      vsync_in = 1'b0; repeat (3) tick();
    end
    check_val("frm_hold", frame_count, 5);
    $display("frames: count %0d", frame_count);

    // ---- randomized run ----
    reset = 1'b1; tick(); reset = 1'b0;
    seg = 0; mode = 0;
    for (int c = 0; c < 5000; c++) begin
      if (seg == 0) begin
        mode = $urandom_range(0, 3);
        seg  = $urandom_range(4, 80);
      end
      seg--;
      case (mode)
        0: set_good(1'b1);
        1: begin hdmi_valid_in = 1'b0; hdmi_locked_in = 1'($urandom_range(0, 1)); end
        2: begin hdmi_valid_in = 1'($urandom_range(0, 1)); hdmi_locked_in = 1'b1; end
        default: begin
          hdmi_valid_in  = ($urandom_range(0, 3) != 0);
          hdmi_locked_in = ($urandom_range(0, 7) != 0);
        end
      endcase
      if ($urandom_range(0, 9) == 0) vsync_in = ~vsync_in;
      enable = ($urandom_range(0, 299) != 0);
      reset  = ($urandom_range(0, 1999) == 0);
      tick();
    end
    reset = 1'b0; enable = 1'b1;
    $display("random: retry %0d loss %0d frames %0d", retry_count, loss_count, frame_count);

    // ---- retry saturation ----
    set_good(1'b0);
    cmp_en = 1'b0;
    prev = int'(state); tcount = 0; n = 0;
    while (tcount < 300 && n < 40000) begin
      tick();
      n++;
      if (prev == 2 && state == 3'd1) tcount++;
      prev = int'(state);
    end
    cmp_en = 1'b1;
    check_val("sat_timeouts", tcount, 300);
    check_val("sat_retry", retry_count, 255);
    cmp_model();
    $display("saturation: %0d timeouts, retry %0d", tcount, retry_count);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
